hilo_muldiv_ctrl: RTL
=====================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequencer for all HI/LO writes: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the
//  execute stage and runs fixed-latency multiply or 32-iteration divide. It stalls
//  the pipeline while busy and drives the write ports of the HI/LO register pair.
//  It is the only writer of HI/LO; MFHI/MFLO read the register directly.
// PARAMETERS
//  MUL_LATENCY  4   cycles from accept to HI/LO write for MULT/MULTU; legal 1..16
// PORTS
//  clk        in   1   clock
//  resetn     in   1   reset: synchronous, active-low
//  req_valid  in   1   execute stage holds a HI/LO-writing instruction
//  req_op     in   3   muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
//  req_a      in   32  rs value (dividend / multiplicand / MT source)
//  req_b      in   32  rt value (divisor / multiplier)
//  flush      in   1   exception/flush: abandon any in-flight op
//  stall      out  1   hold execute stage (combinational)
//  hi_write   out  1   write strobe to HI (combinational)
//  lo_write   out  1   write strobe to LO (combinational)
//  hi_data    out  32  HI write data
//  lo_data    out  32  LO write data
// BEHAVIOUR
//  - Reset (resetn=0 at a clk edge): state<=IDLE, counter<=0, operand/result regs<=0.
//    While resetn=0, stall, hi_write and lo_write are forced to 0.
//  - FSM states:
//    - IDLE: req accepted only here. MTHI/MTLO: hi_write (or lo_write)=1 and
//      hi_data (or lo_data)=req_a in the same cycle; stall=0; stay IDLE.
//      MULT*/DIV*: latch operands and signedness; stall=1 in the accept cycle T0.
//    - MUL: entered at T0+1 if MUL_LATENCY>1 (else straight to FIN at T0+1).
//      Counts down; goes to FIN so that FIN occurs at T0+MUL_LATENCY.
//    - DIV: 32 restoring iterations on magnitudes (T0+1..T0+32), then FIN at T0+33.
//    - FIN: hi_write=lo_write=1, stall=0, next state IDLE unconditionally.
//      req_valid is ignored in FIN, so the same held instruction is not re-accepted.
//  - stall = (state==IDLE && req_valid && op is MUL*/DIV*) || state==MUL || state==DIV.
//  - Requests in MUL/DIV/FIN are ignored; the requester holds them under stall.
//  - Multiply results:
//    - MULT: 64-bit signed product; MULTU: unsigned product.
//    - {hi_data,lo_data} = product.
//    - The product may be computed from the latched operands at any point before FIN.
//  - Divide results:
//    - Signed: quotient sign = a[31]^b[31]; remainder sign = a[31].
//    - Signs are applied in FIN; lo_data = quotient, hi_data = remainder.
//    - 0x80000000 / -1 (signed) -> lo=0x80000000, hi=0.
//    - Divide by zero (either signedness) -> quotient magnitude 0xFFFFFFFF,
//      remainder magnitude |a|, then sign correction as above. Latency is still 33.
//  - flush:
//    - Any state: next state IDLE with no write.
//    - In FIN: hi_write/lo_write are suppressed.
//    - In IDLE with req_valid: no accept, no MT write.
//    - stall=0 whenever flush=1.
//  - Reset mid-operation: the op is discarded, no write, IDLE next cycle.
//  - hi_data/lo_data are don't-care when their strobe is 0; the bench checks them
//    only under strobe.
// STRUCTURE
//  - The shared package holds:
//    - muldiv_op_t enum (3 bits);
//    - localparam DIV_ITERS=32;
//    - word_t from the common header.
//  - Sub-module muldiv_divider: unsigned restoring divider.
//    - Inputs: start, dividend, divisor.
//    - Behaviour: 1 bit per cycle; raises done after 32 cycles with quotient and
//      remainder; clears on abort.
//  - The multiplier stays inline, as a 64-bit '*' on sign-extended 33-bit operands.
// TESTING
//  - MULT a=0xFFFFFFFE b=3 -> stall T0..T0+3, FIN at T0+4: hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  - MULTU a=0xFFFFFFFE b=3 -> FIN at T0+4: hi=0x00000002 lo=0xFFFFFFFA.
//  - DIV a=-7 (0xFFFFFFF9) b=2 -> FIN at T0+33: lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0.
//  - DIVU a=100 b=0 -> T0+33: lo=0xFFFFFFFF hi=0x00000064.
//  - MTHI a=0x1234 -> hi_write=1, hi_data=0x1234, lo_write=0, stall=0 in the same
//    cycle; a back-to-back MTLO next cycle is also written.
//  - DIV flushed at T0+10 -> no strobes ever, stall=0 from T0+10, IDLE at T0+11,
//    then a fresh MULTU is accepted. resetn=0 at T0+5 of a MULT gives the same
//    no-write result.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_t;

  localparam int DIV_ITERS = 32;

  // True for ops that occupy the sequencer for more than one cycle.
  function automatic logic op_is_arith(input muldiv_op_t op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // True for the signed variants.
  function automatic logic op_is_signed(input muldiv_op_t op);
    case (op)
      MD_MULT, MD_DIV: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  // Two's-complement negate when neg is set.
  function automatic word_t neg_if(input logic neg, input word_t v);
    if (neg) begin
      return (~v) + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Magnitude of v when interpreted as signed (sgn=1), else v unchanged.
  function automatic word_t abs_if(input logic sgn, input word_t v);
    return neg_if(sgn & v[31], v);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, 32 cycles per divide.
// Divide by zero naturally yields quotient 0xFFFFFFFF and remainder = dividend.
module muldiv_divider
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  resetn,
  input  logic  start,
  input  logic  abort,
  input  word_t dividend,
  input  word_t divisor,
  output logic  done,
  output word_t quotient,
  output word_t remainder
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic       busy_q, busy_d;
  logic [4:0] iter_q, iter_d;
  word_t      rem_q, rem_d;
  word_t      quo_q, quo_d;
  word_t      dvs_q, dvs_d;
  logic [32:0] shifted_s;
  logic [32:0] trial_s;

  // One restoring step: shift in the next dividend bit and try to subtract.
  always_comb begin
    shifted_s = {rem_q, quo_q[31]};
    trial_s   = shifted_s - {1'b0, dvs_q};
  end

  // Load on start, iterate while busy, drop everything on abort.
  always_comb begin
    busy_d = busy_q;
    iter_d = iter_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (abort) begin
      busy_d = 1'b0;
      iter_d = 5'd0;
    end else if (start) begin
      busy_d = 1'b1;
      iter_d = 5'd0;
      rem_d  = 32'd0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      iter_d = iter_q + 5'd1;
      quo_d  = {quo_q[30:0], ~trial_s[32]};
      if (iter_q == LAST_ITER) begin
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
      if (trial_s[32]) begin
        rem_d = shifted_s[31:0];
      end else begin
        rem_d = trial_s[31:0];
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      iter_q <= 5'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
    end else begin
      busy_q <= busy_d;
      iter_q <= iter_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  // done marks the cycle the final bit is produced; results are in
  // quotient/remainder on the following cycle.
  assign done      = busy_q && (iter_q == LAST_ITER);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: MTHI/MTLO in one cycle, fixed-latency multiply,
// 32-iteration divide. Sole writer of the HI/LO register pair.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  muldiv_op_t  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        stall,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  // The MUL state holds for MUL_LATENCY-1 cycles; the counter reaches zero
  // in the last of them.
  localparam logic [3:0] MUL_CNT_INIT = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

  md_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sgn_q, sgn_d;
  logic       div_q, div_d;
  word_t      a_q, a_d;
  word_t      b_q, b_d;

  logic        accept_s;
  logic        req_div_s;
  logic        req_sgn_s;
  logic        div_done_s;
  word_t       div_quo_s;
  word_t       div_rem_s;
  logic signed [32:0] ea_s;
  logic signed [32:0] eb_s;
  logic signed [63:0] prod_s;
  word_t       fin_hi_s;
  word_t       fin_lo_s;

  // Request decode; a multi-cycle op is taken only in IDLE and never under flush.
  always_comb begin
    req_div_s = (req_op == MD_DIV) || (req_op == MD_DIVU);
    req_sgn_s = op_is_signed(req_op);
    accept_s  = resetn && !flush && (state_q == ST_IDLE) && req_valid && op_is_arith(req_op);
  end

  muldiv_divider u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept_s && req_div_s),
    .abort     (flush),
    .dividend  (abs_if(req_sgn_s, req_a)),
    .divisor   (abs_if(req_sgn_s, req_b)),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // FIN-cycle results: product from latched operands, divide with sign fix-up.
  always_comb begin
    ea_s   = {sgn_q & a_q[31], a_q};
    eb_s   = {sgn_q & b_q[31], b_q};
    prod_s = 64'(ea_s) * 64'(eb_s);
    if (div_q) begin
      fin_lo_s = neg_if(sgn_q & (a_q[31] ^ b_q[31]), div_quo_s);
      fin_hi_s = neg_if(sgn_q & a_q[31], div_rem_s);
    end else begin
      fin_lo_s = prod_s[31:0];
      fin_hi_s = prod_s[63:32];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_div_s) begin
            state_d = ST_DIV;
          end else if (MUL_LATENCY > 1) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Operand latch on accept and multiply countdown.
  always_comb begin
    cnt_d = cnt_q;
    sgn_d = sgn_q;
    div_d = div_q;
    a_d   = a_q;
    b_d   = b_q;
    if (accept_s) begin
      cnt_d = MUL_CNT_INIT;
      sgn_d = req_sgn_s;
      div_d = req_div_s;
      a_d   = req_a;
      b_d   = req_b;
    end else if ((state_q == ST_MUL) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and operand registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 4'd0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      sgn_q <= sgn_d;
      div_q <= div_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  // FSM outputs; reset and flush silence stall and both strobes.
  always_comb begin
    stall    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    hi_data  = 32'd0;
    lo_data  = 32'd0;
    if (!resetn || flush) begin
      stall    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          stall = req_valid && op_is_arith(req_op);
          if (req_valid && (req_op == MD_MTHI)) begin
            hi_write = 1'b1;
            hi_data  = req_a;
          end else begin
            hi_write = 1'b0;
          end
          if (req_valid && (req_op == MD_MTLO)) begin
            lo_write = 1'b1;
            lo_data  = req_a;
          end else begin
            lo_write = 1'b0;
          end
        end
        ST_MUL, ST_DIV: stall = 1'b1;
        ST_FIN: begin
          hi_write = 1'b1;
          lo_write = 1'b1;
          hi_data  = fin_hi_s;
          lo_data  = fin_lo_s;
        end
        default: stall = 1'b0;
      endcase
    end
  end

endmodule
